// File: rtl/mem_read_sched.sv
// mem_read_sched: round-robin scheduler that shares one packet-buffer read
// controller among N_PORTS egress ports. A granted port's head block is read
// first, then one follow-on read is issued per returned block until the block
// carrying end-of-packet arrives. Returned blocks are steered to the owning port.
// A watchdog aborts a chain that stops returning blocks.
module mem_read_sched #(
    parameter int N_PORTS    = 4,
    parameter int ADDR_W     = 10,
    parameter int BLOCK_BITS = 64,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PORTS-1:0]           req_i,
    input  logic [N_PORTS*ADDR_W-1:0]    req_addr_i,
    output logic [N_PORTS-1:0]           gnt_o,
    output logic                         busy_o,
    output logic                         rd_re_o,
    output logic                         rd_start_o,
    output logic [ADDR_W-1:0]            rd_start_addr_o,
    input  logic [BLOCK_BITS-1:0]        rd_data_i,
    input  logic                         rd_data_valid_i,
    input  logic                         rd_data_end_i,
    output logic [BLOCK_BITS-1:0]        port_data_o,
    output logic [N_PORTS-1:0]           port_valid_o,
    output logic [N_PORTS-1:0]           port_end_o,
    output logic                         err_timeout_o,
    output logic [$clog2(N_PORTS)-1:0]   err_port_o
);

    localparam int PW = $clog2(N_PORTS);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [PW-1:0]   last_owner_reg, last_owner_next;
    logic [WW-1:0]   wdog_reg, wdog_next;

    logic [ADDR_W-1:0] addr_arr [N_PORTS];
    logic [PW-1:0]     winner;
    logic              any_req;

    // Unpack the flat per-port head-address bus into an array.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign any_req     = |req_i;
    assign busy_o      = (state_reg != IDLE);
    assign port_data_o = rd_data_i;

    // Round-robin pick: scan from farthest to nearest so the port closest
    // after last_owner is the final (winning) assignment.
    always_comb begin
        int idx;
        winner = last_owner_reg;
        idx    = 0;
        for (int i = N_PORTS; i >= 1; i--) begin
            idx = int'(last_owner_reg) + i;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (req_i[idx]) begin
                winner = PW'(idx);
            end
        end
    end

    // Next-state and output decode for the IDLE/WAIT controller.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        wdog_next       = wdog_reg;
        gnt_o           = '0;
        rd_re_o         = 1'b0;
        rd_start_o      = 1'b0;
        rd_start_addr_o = '0;
        port_valid_o    = '0;
        port_end_o      = '0;
        err_timeout_o   = 1'b0;
        err_port_o      = '0;
        case (state_reg)
            IDLE: begin
                // rst_n gates the same-cycle grant so nothing leaks out while
                // reset is held with requests pending.
                if (rst_n && any_req) begin
                    gnt_o[winner]   = 1'b1;
                    rd_re_o         = 1'b1;
                    rd_start_o      = 1'b1;
                    rd_start_addr_o = addr_arr[winner];
                    owner_next      = winner;
                    last_owner_next = winner;
                    wdog_next       = '0;
                    state_next      = WAIT;
                end
            end
            WAIT: begin
                port_valid_o[owner_reg] = rd_data_valid_i;
                port_end_o[owner_reg]   = rd_data_valid_i & rd_data_end_i;
                if (rd_data_valid_i) begin
                    wdog_next = '0;
                    if (rd_data_end_i) begin
                        state_next = IDLE;
                    end else begin
                        // Controller takes the next address from this block's footer.
                        rd_re_o = 1'b1;
                    end
                end else if (wdog_reg == WD_LAST) begin
                    err_timeout_o = 1'b1;
                    err_port_o    = owner_reg;
                    state_next    = IDLE;
                end else if (wdog_reg != '1) begin
                    wdog_next = wdog_reg + WW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, ownership and watchdog registers; reset leaves port 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= LAST_PORT;
            wdog_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            wdog_reg       <= wdog_next;
        end
    end

endmodule

// File: doc/mem_read_sched.md
# mem_read_sched

Round-robin read scheduler sharing the single packet-buffer read controller among `N_PORTS` egress ports. An egress port posts a packet head address. The scheduler grants one port at a time and starts the linked-list read, issuing one follow-on read per returned block until end-of-packet. It steers returned blocks to the owning port and recovers from a stalled chain with a watchdog. It sits between the egress queues and the memory read controller.

## Interface
- `N_PORTS`, 4, number of requesting egress ports (≥2)
- `ADDR_W`, 10, block address width (matches buffer package)
- `BLOCK_BITS`, 64, block width including 16-bit footer
- `TIMEOUT`, 16, max cycles in WAIT without a returned block before abort (≥4)
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_i` in N_PORTS: per-port packet read request, held until granted
- `req_addr_i` in N_PORTS*ADDR_W: per-port head block address, slice p = `[p*ADDR_W +: ADDR_W]`, stable while `req_i[p]`
- `gnt_o` out N_PORTS: one-hot, 1-cycle pulse, request consumed
- `busy_o` out 1: packet in flight (state ≠ IDLE)
- `rd_re_o` out 1: read enable to read controller
- `rd_start_o` out 1: first-block read, selects `rd_start_addr_o`
- `rd_start_addr_o` out ADDR_W: head address of granted port
- `rd_data_i` in BLOCK_BITS: block from read controller
- `rd_data_valid_i` in 1: block valid
- `rd_data_end_i` in 1: block is last of packet (footer eop)
- `port_data_o` out BLOCK_BITS: `rd_data_i` broadcast to all ports
- `port_valid_o` out N_PORTS: one-hot block valid to owner
- `port_end_o` out N_PORTS: one-hot last-block flag to owner
- `err_timeout_o` out 1: 1-cycle pulse on watchdog abort
- `err_port_o` out $clog2(N_PORTS): owner of aborted packet, valid with `err_timeout_o`

## Operation
- States: IDLE, WAIT.
- IDLE: if any `req_i`, choose the winner by round-robin. Search starts at `last_owner+1` mod N_PORTS. In the same cycle, drive `rd_re_o=1`, `rd_start_o=1`, `rd_start_addr_o=req_addr_i[winner]` and `gnt_o[winner]=1`. Register `owner=winner` and `last_owner=winner`, clear the watchdog, and go to WAIT. No request: all outputs 0, stay.
- WAIT: `port_valid_o[owner]=rd_data_valid_i` and `port_end_o[owner]=rd_data_valid_i & rd_data_end_i`, both combinational.
  - Valid, not end: `rd_re_o=1`, `rd_start_o=0`. The controller supplies the next address from the footer. Clear the watchdog and stay.
  - Valid and end: no read is issued. Go to IDLE.
  - No valid: increment the watchdog. At count `TIMEOUT-1`, pulse `err_timeout_o` with `err_port_o=owner` and go to IDLE. No `port_end_o` is generated.
- `rd_data_valid_i` in IDLE is ignored. `port_valid_o` stays 0.
- Requests arriving during WAIT wait. `gnt_o` never asserts outside IDLE.
- Watchdog width: $clog2(TIMEOUT); it saturates and never wraps.
- Reset (any time, including mid-packet): state IDLE, `owner=0`, `last_owner=N_PORTS-1` (so port 0 wins first), watchdog 0. The in-flight packet is dropped without an end flag.

## Timing
- Reset values: every output 0, including `busy_o`, `gnt_o`, `rd_*_o`, `port_*_o`, `err_*_o`. `port_data_o` follows `rd_data_i`.
- Grant, `rd_re_o` and `rd_start_o` are combinational in the same IDLE cycle as `req_i` (T). Requester deasserts or changes `req_i` from T+1.
- Read controller latency is 2 cycles: the block for the read at T returns as `rd_data_valid_i` at T+2.
- Steady state is 1 block per 2 cycles.
- `busy_o` is high from T+1 through the cycle the last block is seen. Next grant no earlier than the cycle after the end block.
- Single-block packet: first returned block has end set → IDLE, no further read.

## Test plan
- Port 1 requests addr 0x020, chain of 3 blocks, eop on 3rd:
  - `gnt_o=0010` and `rd_start_o` at T;
  - `port_valid_o[1]` at T+2, T+4, T+6;
  - `port_end_o[1]` at T+6;
  - `rd_re_o` at T, T+2, T+4 only.
- All 4 ports request continuously, 1-block packets: grants in order 0,1,2,3,0. Each grant is 3 cycles after the previous one.
- Port 2 requests while port 0's packet is in flight: no `gnt_o` until port 0's end block. Port 2 is granted the cycle after.
- Granted packet returns one block, then no more valid for 16 cycles: `err_timeout_o=1` with `err_port_o=owner` on the 16th stalled cycle. Back in IDLE, the next pending request is granted the cycle after.
- `rst_n` low mid-packet (after 1 of 4 blocks): all outputs 0 immediately. After release, port 0 wins against simultaneous requests from ports 0 and 3.
- Single-block packet, head addr 0x3FF (all-ones): `rd_start_addr_o=0x3FF`, `port_end_o` on the first valid, no second `rd_re_o`.
